// File: rtl/counter99_pkg.sv
// -----------------------------------------------------------------------------
// counter99_pkg
// Shared types and constants for the 00-99 counter run/pause/clear sequencer.
//   state_t       : sequencer FSM state encoding (IDLE, RUN, PAUSE, DONE)
//   DEF_WIDTH     : default width of the counter value bus
//   DEF_MAX_COUNT : default terminal count
//   presc_width() : bit width needed for a prescaler counting 0..tick_div-1
// Optional feature macro used by the importing files: COUNTER99_AUTO_WRAP_EN
// -----------------------------------------------------------------------------
package counter99_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_RUN   = 2'd1,
      ST_PAUSE = 2'd2,
      ST_DONE  = 2'd3
   } state_t;

   localparam int DEF_WIDTH     = 8;
   localparam int DEF_MAX_COUNT = 99;

   // clog2(tick_div) bits hold 0..tick_div-1; never narrower than 1 bit.
   function automatic int presc_width(input int tick_div);
      return (tick_div > 2) ? $clog2(tick_div) : 1;
   endfunction

endpackage

// File: rtl/counter99_ctrl_btn_debounce.sv
// -----------------------------------------------------------------------------
// btn_debounce
// Two-flop synchroniser, stability-counter debouncer and rising-edge pulse for
// one raw push-button.
// Ports:
//   clk      : clock
//   rst_n    : asynchronous active-low reset
//   i_btn    : raw button level, asynchronous to clk
//   o_press  : one-cycle pulse in the cycle the debounced level rises
// Parameter:
//   DB_CYCLES: consecutive disagreeing samples needed to flip the level (>=2)
// Raw-to-pulse latency is 2 + DB_CYCLES clocks.
// -----------------------------------------------------------------------------
module btn_debounce #(
   parameter int DB_CYCLES = 4
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_btn,
   output logic o_press
);

   localparam int              CW       = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
   localparam logic [CW-1:0]   CNT_LAST = CW'(DB_CYCLES - 1);

   logic          r_sync1;
   logic          r_sync2;
   logic          r_level;
   logic          r_press;
   logic [CW-1:0] r_stable_cnt;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1      <= 1'b0;
         r_sync2      <= 1'b0;
         r_level      <= 1'b0;
         r_press      <= 1'b0;
         r_stable_cnt <= '0;
      end else begin
         r_sync1 <= i_btn;
         r_sync2 <= r_sync1;
         r_press <= 1'b0;
         if (r_sync2 == r_level) begin
            // Any agreeing sample restarts the stability window.
            r_stable_cnt <= '0;
         end else if (r_stable_cnt == CNT_LAST) begin
            // DB_CYCLES-th consecutive disagreeing sample: accept the new level.
            r_level      <= r_sync2;
            r_press      <= r_sync2;
            r_stable_cnt <= '0;
         end else begin
            r_stable_cnt <= r_stable_cnt + 1'b1;
         end
      end
   end

   assign o_press = r_press;

endmodule

// File: rtl/counter99_ctrl.sv
// -----------------------------------------------------------------------------
// counter99_ctrl
// Run/pause/clear sequencer for the 00-99 display counter. Debounces the
// start/stop and clear buttons, runs an IDLE/RUN/PAUSE/DONE state machine and
// divides clk into count ticks, driving the counter with registered
// single-cycle increment and clear strobes.
// Ports:
//   clk         : clock (divided display clock domain)
//   rst_n       : asynchronous active-low reset
//   btn_ss      : raw start/stop button, active-high, asynchronous
//   btn_clr     : raw clear button, active-high, asynchronous
//   count       : current counter value
//   cnt_inc     : one-cycle increment strobe
//   cnt_clr     : one-cycle synchronous clear strobe
//   running     : high while in RUN
//   done        : high while in DONE
//   o_dbg_state : registered FSM state, for observation only
// Optional feature: define COUNTER99_AUTO_WRAP_EN to make a terminal-count tick
// clear the counter and keep running (DONE unreachable, done tied 0). Without
// it, a terminal-count tick emits no strobe and parks the FSM in DONE.
// -----------------------------------------------------------------------------
module counter99_ctrl
   import counter99_pkg::*;
#(
   parameter int WIDTH     = DEF_WIDTH,
   parameter int MAX_COUNT = DEF_MAX_COUNT,
   parameter int DB_CYCLES = 4,
   parameter int TICK_DIV  = 190
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             btn_ss,
   input  logic             btn_clr,
   input  logic [WIDTH-1:0] count,
   output logic             cnt_inc,
   output logic             cnt_clr,
   output logic             running,
   output logic             done,
   output state_t           o_dbg_state
);

   localparam int               PW         = presc_width(TICK_DIV);
   localparam logic [PW-1:0]    PRESC_LAST = PW'(TICK_DIV - 1);
   localparam logic [WIDTH-1:0] MAX_VAL    = WIDTH'(MAX_COUNT);

   logic          w_ss_p;
   logic          w_clr_p;
   logic          w_tick;
   logic          w_terminal;
   state_t        r_state;
   state_t        w_state_nxt;
   logic [PW-1:0] r_presc;
   logic [PW-1:0] w_presc_nxt;
   logic          r_cnt_inc;
   logic          r_cnt_clr;
   logic          w_inc_nxt;
   logic          w_clr_nxt;

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_ss (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_btn   (btn_ss),
      .o_press (w_ss_p)
   );

   btn_debounce #(.DB_CYCLES(DB_CYCLES)) u_db_clr (
      .clk     (clk),
      .rst_n   (rst_n),
      .i_btn   (btn_clr),
      .o_press (w_clr_p)
   );

   assign w_tick     = (r_state == ST_RUN) && (r_presc == PRESC_LAST);
   // Out-of-range values are treated as terminal so the counter can never run away.
   assign w_terminal = (count >= MAX_VAL);

   // State register, prescaler and registered strobes.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state   <= ST_IDLE;
         r_presc   <= '0;
         r_cnt_inc <= 1'b0;
         r_cnt_clr <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_presc   <= w_presc_nxt;
         r_cnt_inc <= w_inc_nxt;
         r_cnt_clr <= w_clr_nxt;
      end
   end

   // Next state and prescaler. Clear beats every other event.
   always_comb begin
      w_state_nxt = r_state;
      w_presc_nxt = r_presc;
      if (w_clr_p) begin
         w_state_nxt = ST_IDLE;
         w_presc_nxt = '0;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (w_ss_p) begin
                  w_state_nxt = ST_RUN;
                  w_presc_nxt = '0;
               end
            end
            ST_RUN: begin
               w_presc_nxt = (r_presc == PRESC_LAST) ? '0 : (r_presc + 1'b1);
`ifdef COUNTER99_AUTO_WRAP_EN
               if (w_ss_p) begin
                  w_state_nxt = ST_PAUSE;
               end
`else
               // A terminal tick parks in DONE even if a pause press coincides.
               if (w_tick && w_terminal) begin
                  w_state_nxt = ST_DONE;
               end else if (w_ss_p) begin
                  w_state_nxt = ST_PAUSE;
               end
`endif
            end
            ST_PAUSE: begin
               // Prescaler holds, so a resume continues the interrupted tick period.
               if (w_ss_p) begin
                  w_state_nxt = ST_RUN;
               end
            end
            ST_DONE: begin
               w_state_nxt = ST_DONE;
            end
            default: begin
               w_state_nxt = ST_IDLE;
            end
         endcase
      end
   end

   // Strobe decode; registered above so strobes land one cycle after the event.
   always_comb begin
      w_inc_nxt = 1'b0;
      w_clr_nxt = 1'b0;
      if (w_clr_p) begin
         w_clr_nxt = 1'b1;
      end else if (w_tick && !w_terminal) begin
         w_inc_nxt = 1'b1;
      end else if (w_tick) begin
`ifdef COUNTER99_AUTO_WRAP_EN
         w_clr_nxt = 1'b1;
`else
         // Terminal tick: no strobe, the counter holds at MAX_COUNT.
         w_clr_nxt = 1'b0;
`endif
      end
   end

   assign cnt_inc     = r_cnt_inc;
   assign cnt_clr     = r_cnt_clr;
   assign running     = (r_state == ST_RUN);
`ifdef COUNTER99_AUTO_WRAP_EN
   assign done        = 1'b0;
`else
   assign done        = (r_state == ST_DONE);
`endif
   assign o_dbg_state = r_state;

endmodule
